lfsr_check: RTL and testbench

Self-synchronising checker for the random-replacement LFSR used in the caches. It samples the generator's state word every time the generator advances and predicts the next state from the same per-width feedback polynomial. It locks onto the sequence, flags deviations, counts errors, and detects the all-zero lockup state. It sits beside a cache's replacement logic as a hardware monitor and is also instantiated in the verification harness.

---
 rtl/lfsr_check.sv | 185 ++++++++++++++++++
 tb/tb_lfsr_check.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_check.sv
// Self-synchronising checker for the cache random-replacement LFSR: locks onto the
// observed state sequence, flags mispredictions, counts errors and detects all-zero lockup.
module lfsr_check #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_N   = 4,
    parameter int unsigned UNLOCK_N = 3,
    parameter int unsigned CNTW     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FlushStage,
    input  logic             Advance,
    input  logic [WIDTH-1:0] Din,
    input  logic             Clear,
    output logic             Locked,
    output logic             Error,
    output logic [CNTW-1:0]  ErrCount,
    output logic             Stuck,
    output logic [WIDTH-1:0] Expected
);

    localparam int unsigned MatchW = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
    localparam int unsigned MissW  = (UNLOCK_N > 1) ? $clog2(UNLOCK_N) : 1;
    localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_N - 1);
    localparam logic [MissW-1:0]  MissLast  = MissW'(UNLOCK_N - 1);

    if (WIDTH < 3 || WIDTH > 9) begin : g_bad_width
        $error("lfsr_check: WIDTH must be in 3..9");
    end
    if (LOCK_N < 1) begin : g_bad_lock
        $error("lfsr_check: LOCK_N must be at least 1");
    end
    if (UNLOCK_N < 1) begin : g_bad_unlock
        $error("lfsr_check: UNLOCK_N must be at least 1");
    end
    if (CNTW < 1) begin : g_bad_cntw
        $error("lfsr_check: CNTW must be at least 1");
    end

    typedef enum logic [1:0] {
        StUnlocked,
        StTrain,
        StLocked
    } state_e;

    // Taps are read from a zero-extended copy so every WIDTH shares one index range.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
        logic [8:0] p;
        logic       fb;
        p = 9'(x);
        case (WIDTH)
            3:       fb = p[2] ^ p[0];
            4:       fb = p[3] ^ p[0];
            5:       fb = p[4] ^ p[3] ^ p[1] ^ p[0];
            6:       fb = p[5] ^ p[4] ^ p[2] ^ p[1];
            7:       fb = p[6] ^ p[5] ^ p[3] ^ p[0];
            8:       fb = p[7] ^ p[5] ^ p[2] ^ p[1];
            9:       fb = p[8] ^ p[6] ^ p[5] ^ p[4] ^ p[3] ^ p[2];
            default: fb = 1'b0;
        endcase
        return {fb, x[WIDTH-1:1]};
    endfunction

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  expected_q, expected_d;
    logic [MatchW-1:0] match_q, match_d;
    logic [MissW-1:0]  miss_q, miss_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              stuck_q, stuck_d;

    logic sample;
    logic hit;

    assign sample = Advance & ~FlushStage;
    assign hit    = (Din == expected_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StUnlocked;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Clear) begin
            state_d = StUnlocked;
        end else if (sample) begin
            unique case (state_q)
                StUnlocked: state_d = StTrain;
                StTrain: begin
                    if (hit && match_q == MatchLast) begin
                        state_d = StLocked;
                    end
                end
                StLocked: begin
                    if (!hit && miss_q == MissLast) begin
                        state_d = StUnlocked;
                    end
                end
                default: state_d = StUnlocked;
            endcase
        end
    end

    always_comb begin
        expected_d = expected_q;
        match_d    = match_q;
        miss_d     = miss_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        stuck_d    = stuck_q;
        if (Clear) begin
            // Clear discards any coincident sample, so Expected is left alone.
            cnt_d   = '0;
            stuck_d = 1'b0;
            match_d = '0;
            miss_d  = '0;
        end else if (sample) begin
            if (Din == '0) begin
                stuck_d = 1'b1;
            end
            unique case (state_q)
                StUnlocked: begin
                    expected_d = lfsr_next(Din);
                    match_d    = '0;
                end
                StTrain: begin
                    expected_d = lfsr_next(Din);
                    if (!hit) begin
                        match_d = '0;
                    end else if (match_q == MatchLast) begin
                        match_d = '0;
                        miss_d  = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                StLocked: begin
                    // Flywheel on our own prediction so a single bad sample cannot reseed.
                    expected_d = lfsr_next(expected_q);
                    if (hit) begin
                        miss_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (!(&cnt_q)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        miss_d = (miss_q == MissLast) ? '0 : miss_q + 1'b1;
                    end
                end
                default: expected_d = expected_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            expected_q <= '0;
            match_q    <= '0;
            miss_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            expected_q <= expected_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            stuck_q    <= stuck_d;
        end
    end

    always_comb begin
        Locked   = (state_q == StLocked);
        Error    = err_q;
        ErrCount = cnt_q;
        Stuck    = stuck_q;
        Expected = expected_q;
    end

endmodule

// File: tb/tb_lfsr_check.sv
// Bench for lfsr_check: two configurations driven by directed and random samples, checked
// against a behavioural model built from tap masks and plain counters.
module tb_lfsr_check;

    localparam int WA = 4;
    localparam int WB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic          fl_a, adv_a, clr_a;
    logic [WA-1:0] din_a;
    logic          locked_a, err_a, stuck_a;
    logic [7:0]    cnt_a;
    logic [WA-1:0] exp_a;

    logic          fl_b, adv_b, clr_b;
    logic [WB-1:0] din_b;
    logic          locked_b, err_b, stuck_b;
    logic [1:0]    cnt_b;
    logic [WB-1:0] exp_b;

    lfsr_check #(.WIDTH(WA), .LOCK_N(4), .UNLOCK_N(3), .CNTW(8)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .FlushStage (fl_a),
        .Advance    (adv_a),
        .Din        (din_a),
        .Clear      (clr_a),
        .Locked     (locked_a),
        .Error      (err_a),
        .ErrCount   (cnt_a),
        .Stuck      (stuck_a),
        .Expected   (exp_a)
    );

    lfsr_check #(.WIDTH(WB), .LOCK_N(2), .UNLOCK_N(8), .CNTW(2)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .FlushStage (fl_b),
        .Advance    (adv_b),
        .Din        (din_b),
        .Clear      (clr_b),
        .Locked     (locked_b),
        .Error      (err_b),
        .ErrCount   (cnt_b),
        .Stuck      (stuck_b),
        .Expected   (exp_b)
    );

    typedef struct packed {
        logic        locked;
        logic        training;
        logic [31:0] pred;
        logic [31:0] run;
        logic [31:0] errs;
        logic        stuck;
        logic        err;
    } mdl_t;

    int   vectors = 0;
    int   miscompares = 0;
    mdl_t ma, mb;

    function automatic int nx(input int x, input int w);
        int mask;
        int fb;
        case (w)
            3:       mask = 32'h005;
            4:       mask = 32'h009;
            5:       mask = 32'h01B;
            6:       mask = 32'h036;
            7:       mask = 32'h069;
            8:       mask = 32'h0A6;
            9:       mask = 32'h17C;
            default: mask = 0;
        endcase
        fb = $countones(x & mask) % 2;
        return (x >> 1) | (fb << (w - 1));
    endfunction

    function automatic mdl_t mreset();
        mdl_t m;
        m = '0;
        return m;
    endfunction

    function automatic mdl_t mstep(input mdl_t m_in, input bit adv, input bit fl, input int din,
                                   input bit clr, input int w, input int lockn, input int unlockn,
                                   input int errmax);
        mdl_t m;
        m = m_in;
        m.err = 1'b0;
        if (clr) begin
            m.errs = 0;
            m.stuck = 1'b0;
            m.locked = 1'b0;
            m.training = 1'b0;
            m.run = 0;
            return m;
        end
        if (!adv || fl) return m;
        if (din == 0) m.stuck = 1'b1;
        if (m.locked) begin
            if (din != int'(m.pred)) begin
                m.err = 1'b1;
                if (int'(m.errs) < errmax) m.errs = m.errs + 1;
                m.run = m.run + 1;
                if (int'(m.run) == unlockn) begin
                    m.locked = 1'b0;
                    m.run = 0;
                end
            end else begin
                m.run = 0;
            end
            m.pred = nx(int'(m.pred), w);
        end else if (m.training) begin
            if (din == int'(m.pred)) begin
                m.run = m.run + 1;
                if (int'(m.run) == lockn) begin
                    m.locked = 1'b1;
                    m.training = 1'b0;
                    m.run = 0;
                end
            end else begin
                m.run = 0;
            end
            m.pred = nx(din, w);
        end else begin
            m.pred = nx(din, w);
            m.training = 1'b1;
            m.run = 0;
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_a(input string tag);
        chk({tag, ".A.Locked"},   32'(locked_a), 32'(ma.locked));
        chk({tag, ".A.Error"},    32'(err_a),    32'(ma.err));
        chk({tag, ".A.ErrCount"}, 32'(cnt_a),    ma.errs);
        chk({tag, ".A.Stuck"},    32'(stuck_a),  32'(ma.stuck));
        chk({tag, ".A.Expected"}, 32'(exp_a),    ma.pred);
    endtask

    task automatic check_b(input string tag);
        chk({tag, ".B.Locked"},   32'(locked_b), 32'(mb.locked));
        chk({tag, ".B.Error"},    32'(err_b),    32'(mb.err));
        chk({tag, ".B.ErrCount"}, 32'(cnt_b),    mb.errs);
        chk({tag, ".B.Stuck"},    32'(stuck_b),  32'(mb.stuck));
        chk({tag, ".B.Expected"}, 32'(exp_b),    mb.pred);
    endtask

    task automatic step_a(input bit adv, input bit fl, input int din, input bit clr,
                          input string tag);
        int d;
        d = din & 32'hF;
        adv_a = adv;
        fl_a  = fl;
        din_a = WA'(d);
        clr_a = clr;
        @(posedge clk);
        ma = mstep(ma, adv, fl, d, clr, WA, 4, 3, 255);
        #1;
        check_a(tag);
        adv_a = 1'b0;
        fl_a  = 1'b0;
        clr_a = 1'b0;
    endtask

    task automatic step_b(input bit adv, input bit fl, input int din, input bit clr,
                          input string tag);
        int d;
        d = din & 32'h1F;
        adv_b = adv;
        fl_b  = fl;
        din_b = WB'(d);
        clr_b = clr;
        @(posedge clk);
        mb = mstep(mb, adv, fl, d, clr, WB, 2, 8, 3);
        #1;
        check_b(tag);
        adv_b = 1'b0;
        fl_b  = 1'b0;
        clr_b = 1'b0;
    endtask

    initial begin
        int seq1[5];
        int g;
        int pulses;
        bit adv;
        bit fl;
        bit clr;
        int d;

        seq1 = '{2, 1, 8, 12, 14};
        reset = 1'b0;
        {fl_a, adv_a, clr_a, fl_b, adv_b, clr_b} = '0;
        din_a = '0;
        din_b = '0;
        ma = mreset();
        mb = mreset();
        #12;
        check_a("reset");
        check_b("reset");
        @(negedge clk);
        reset = 1'b1;

        // Seed plus four matches reaches lock.
        for (int i = 0; i < 5; i++) step_a(1'b1, 1'b0, seq1[i], 1'b0, "lock");
        chk("lock.Locked", 32'(locked_a), 32'd1);
        chk("lock.Expected", 32'(exp_a), 32'hF);

        // All-zero injection in place of 1111.
        step_a(1'b1, 1'b0, 0, 1'b0, "zero");
        chk("zero.Error", 32'(err_a), 32'd1);
        chk("zero.ErrCount", 32'(cnt_a), 32'd1);
        chk("zero.Stuck", 32'(stuck_a), 32'd1);
        chk("zero.Expected", 32'(exp_a), 32'h7);
        step_a(1'b1, 1'b0, 7, 1'b0, "resume");
        step_a(1'b1, 1'b0, 11, 1'b0, "resume");
        chk("resume.Locked", 32'(locked_a), 32'd1);
        chk("resume.Error", 32'(err_a), 32'd0);
        step_a(1'b0, 1'b0, 0, 1'b0, "idle");

        // Three consecutive misses drop lock.
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, 1'b0, int'(ma.pred) ^ 1, 1'b0, "miss3");
            chk("miss3.Error", 32'(err_a), 32'd1);
        end
        chk("miss3.ErrCount", 32'(cnt_a), 32'd4);
        chk("miss3.Locked", 32'(locked_a), 32'd0);
        step_a(1'b1, 1'b0, 5, 1'b0, "reseed");
        chk("reseed.Expected", 32'(exp_a), 32'hA);
        for (int i = 0; i < 4; i++) step_a(1'b1, 1'b0, int'(ma.pred), 1'b0, "relock");
        chk("relock.Locked", 32'(locked_a), 32'd1);
        step_a(1'b1, 1'b0, int'(ma.pred) ^ 2, 1'b0, "miss1");
        chk("miss1.ErrCount", 32'(cnt_a), 32'd5);

        // Flushed advances are ignored.
        for (int i = 0; i < 5; i++) step_a(1'b1, 1'b1, int'($urandom_range(0, 15)), 1'b0, "flush");
        chk("flush.Locked", 32'(locked_a), 32'd1);
        chk("flush.ErrCount", 32'(cnt_a), 32'd5);

        // Clear beats a coincident mismatching sample.
        step_a(1'b1, 1'b0, int'(ma.pred) ^ 1, 1'b1, "clear");
        chk("clear.ErrCount", 32'(cnt_a), 32'd0);
        chk("clear.Stuck", 32'(stuck_a), 32'd0);
        chk("clear.Locked", 32'(locked_a), 32'd0);
        chk("clear.Error", 32'(err_a), 32'd0);

        // Narrow counter saturates while lock is held.
        g = int'($urandom_range(1, 31));
        step_b(1'b1, 1'b0, g, 1'b0, "bseed");
        for (int i = 0; i < 2; i++) step_b(1'b1, 1'b0, int'(mb.pred), 1'b0, "block");
        chk("block.Locked", 32'(locked_b), 32'd1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step_b(1'b1, 1'b0, int'(mb.pred) ^ 16, 1'b0, "bsat");
            if (err_b === 1'b1) pulses++;
        end
        chk("bsat.pulses", 32'(pulses), 32'd5);
        chk("bsat.ErrCount", 32'(cnt_b), 32'd3);
        chk("bsat.Locked", 32'(locked_b), 32'd1);

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b0;
        #1;
        ma = mreset();
        mb = mreset();
        check_a("areset");
        check_b("areset");
        @(negedge clk);
        reset = 1'b1;

        // Random phase: mostly-faithful generator with glitches, flushes and clears.
        g = int'($urandom_range(1, 15));
        for (int i = 0; i < 300; i++) begin
            adv = ($urandom_range(0, 9) < 8);
            fl  = ($urandom_range(0, 9) == 0);
            clr = ($urandom_range(0, 49) == 0);
            d   = ($urandom_range(0, 9) < 9) ? g : int'($urandom_range(0, 15));
            step_a(adv, fl, d, clr, "randA");
            if (adv && !fl) g = nx(g, WA);
        end
        g = int'($urandom_range(1, 31));
        for (int i = 0; i < 200; i++) begin
            adv = ($urandom_range(0, 9) < 8);
            fl  = ($urandom_range(0, 9) == 0);
            clr = ($urandom_range(0, 49) == 0);
            d   = ($urandom_range(0, 9) < 8) ? g : int'($urandom_range(0, 31));
            step_b(adv, fl, d, clr, "randB");
            if (adv && !fl) g = nx(g, WB);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
